// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the default operand width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used by the serial datapath, one bit per clock.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic c_out,
  output logic s
);

  assign s     = a ^ b ^ c;
  assign c_out = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: LSB first, one bit per cycle,
// subtract done as a + ~b + 1 by preloading the carry with 1.
module serial_add_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_c;

  full_adder u_full_adder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .c_out (fa_c),
    .s     (fa_s)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB and fa_c the carry out.
        if (cnt_q == LAST_CNT) begin
          c_out_d = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8; operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit; request to begin an operation, sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1 bit; operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have ports a and b, inputs, WIDTH bits each; operands, sampled with start.
REQ-007 SHALL have port busy, output, 1 bit; high while serial computation is in progress.
REQ-008 SHALL have port done, output, 1 bit; one-cycle pulse marking that the result is valid.
REQ-009 SHALL have port s, output, WIDTH bits; the sum or difference.
REQ-010 SHALL have port c_out, output, 1 bit; carry out of the MSB (for subtract, 1 = no borrow).
REQ-011 SHALL have port ovf, output, 1 bit; two's-complement signed overflow.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL, at the clock edge, load operand A = a and operand B = (sub ? ~b : b), load carry register = sub, clear the bit counter, and go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL add A[0], B[0] and the carry register in one full adder.
REQ-015 In SHIFT, each cycle SHALL shift the sum bit into the MSB of the result register, shift it right, and shift A and B right by one.
REQ-016 In SHIFT, each cycle SHALL update the carry register and increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-018 On the final SHIFT cycle, the carry into the MSB SHALL be captured to form ovf = carry_in_msb XOR carry_out_msb.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 If start is sampled at edge k, busy SHALL be 1 during cycles k+1..k+WIDTH.
REQ-021 If start is sampled at edge k, done SHALL be 1 during cycle k+WIDTH+1 only.
REQ-022 The total latency from start to done SHALL be WIDTH+1 cycles.
REQ-023 s, c_out and ovf SHALL be valid from the done cycle and held unchanged until the next accepted start.
REQ-024 s SHALL change only while busy=1.
REQ-025 start SHALL be ignored while busy=1 or done=1; there are no queuing and no error flags.
REQ-026 start asserted in the same cycle done=1 SHALL be ignored; a new start is accepted in IDLE only.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-028 A change on a, b or sub after start is accepted SHALL have no effect on the result.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, s=0, c_out=0, ovf=0.
REQ-030 rst=1 at a clock edge SHALL clear the operand registers, the carry register and the counter.
REQ-031 rst SHALL take priority over start.
REQ-032 rst during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-033 After reset is released, the first start SHALL be accepted on the next edge.

Structure
REQ-034 A shared package serial_pkg SHALL hold the FSM state encodings (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-035 The counter width SHALL be $clog2(WIDTH+1).
REQ-036 The per-bit sum/carry SHALL be computed by one instance of the existing full_adder sub-module (ports a, b, c, c_out, s).
REQ-037 No other sub-modules SHALL be used.

Verification (WIDTH=8)
REQ-038 SHALL check add 100+27: start at edge k -> done in cycle k+9 with s=127, c_out=0, ovf=0, and busy high for cycles k+1..k+8.
REQ-039 SHALL check add 127+1 -> s=0x80, c_out=0, ovf=1.
REQ-040 SHALL check add 255+1 -> s=0x00, c_out=1, ovf=0.
REQ-041 SHALL check sub 5-7 -> s=0xFE, c_out=0, ovf=0.
REQ-042 SHALL check sub 0x80-0x01 -> s=0x7F, c_out=1, ovf=1.
REQ-043 SHALL check control behaviour: start pulsed during the 3rd SHIFT cycle -> ignored and the original result unchanged; rst during the 4th SHIFT cycle -> next cycle busy=0, s=0, and no done pulse; a start after reset -> correct result.
